// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-stage enable/bubble/flush control from load-use stalls, branch redirects and dmem waits.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_rs,
  input  logic                 stall_rt,
  input  logic                 br_redirect,
  input  logic [31:0]          br_target,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 pc_redirect,
  output logic [31:0]          redirect_pc,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_en,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 mem_wb_bubble,
  output logic                 wait_err,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);
  typedef enum logic {RUN, DMEM_WAIT} state_t;
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] LIM = WW'(WAIT_LIMIT);
  state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic wait_err_q, wait_err_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
  logic ld_use, freeze, br_run, redir;
  always_comb begin
    ld_use = stall_rs | stall_rt;
    freeze = (state_q == DMEM_WAIT) ? ~dmem_ready : (dmem_req & ~dmem_ready);
    // EX is frozen during a wait, so a branch pulse only counts when it arrives in RUN
    br_run = (state_q == RUN) & br_redirect;
    redir = ~freeze & (br_run | pend_q);
    pc_en = ~freeze & (redir | ~ld_use);
    pc_redirect = redir;
    redirect_pc = br_run ? br_target : pend_pc_q;
    if_id_en = ~freeze & (redir | ~ld_use);
    if_id_flush = redir;
    id_ex_en = ~freeze;
    id_ex_bubble = ~freeze & (redir | ld_use);
    ex_mem_en = ~freeze;
    mem_wb_en = ~freeze;
    mem_wb_bubble = freeze;
    if (rst) begin
      pc_en = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = '0;
      if_id_en = 1'b0;
      if_id_flush = 1'b1;
      id_ex_en = 1'b0;
      id_ex_bubble = 1'b1;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      mem_wb_bubble = 1'b1;
    end
    state_d = freeze ? DMEM_WAIT : RUN;
    wait_cnt_d = ~freeze ? '0 : (state_q == RUN) ? WW'(1) :
                 (wait_cnt_q == LIM) ? wait_cnt_q : wait_cnt_q + 1'b1;
    wait_err_d = wait_err_q | (freeze & (wait_cnt_d == LIM));
    pend_d = redir ? 1'b0 : (br_run & freeze) ? 1'b1 : pend_q;
    pend_pc_d = (br_run & freeze) ? br_target : pend_pc_q;
    stall_d = (~pc_en & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    flush_d = (redir & ~&flush_q) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q <= 1'b0;
      pend_pc_q <= '0;
      wait_cnt_q <= '0;
      wait_err_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pend_pc_q <= pend_pc_d;
      wait_cnt_q <= wait_cnt_d;
      wait_err_q <= wait_err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign wait_err = wait_err_q;
  assign stall_cycles = stall_q;
  assign flush_count = flush_q;
endmodule
